// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_pkg;

  // Smallest operand width the datapath supports (one-bit counter, two-bit product halves).
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= MIN_WIDTH) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle between a requester and the shift-add multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; requester must hold Start until Done and may only drive operands in IDLE.
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic             Start;
  logic             Load_B;
  logic             Signed_Mode;
  logic [WIDTH-1:0] Din;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] A_Out;
  logic [WIDTH-1:0] B_Out;
  logic             X;

  modport master (
    output Start, Load_B, Signed_Mode, Din,
    input  Busy, Done, A_Out, B_Out, X
  );

  modport slave (
    input  Start, Load_B, Signed_Mode, Din,
    output Busy, Done, A_Out, B_Out, X
  );

endinterface

// File: rtl/shift_add_multiplier_addsub.sv
// WIDTH+1-bit adder/subtractor with selectable sign or zero extension of both operands.
// Latency: combinational.
// Backpressure: none.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sign_ext,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  // Widen both operands by one bit so the carry/sign lands in the extension bit.
  always_comb begin
    a_ext = {sign_ext & a[WIDTH-1], a};
    b_ext = {sign_ext & b[WIDTH-1], b};
    sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: {A,B} <= B * S, one ADD + one SHIFT per multiplier bit.
// Latency: Done rises 2*WIDTH cycles after the edge that captures Start; stays until Start drops.
// Backpressure: inputs ignored while Busy; signed mode only when SHIFT_ADD_MULT_SIGNED_EN is defined.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  shift_add_multiplier_if.slave  bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             as_sub;
  logic             as_sext;
  logic [WIDTH:0]   as_sum;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  // Two's-complement: the top multiplier bit carries negative weight, so subtract on the last step.
  assign as_sext = mode_q;
  assign as_sub  = mode_q && (cnt_q == LAST);
`else
  assign as_sext = 1'b0;
  assign as_sub  = 1'b0;
`endif

  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .a        (a_q),
    .b        (s_q),
    .sub      (as_sub),
    .sign_ext (as_sext),
    .sum      (as_sum)
  );

  // State and datapath registers; reset clears everything, even mid-operation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates for IDLE / ADD / SHIFT / DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // Load_B wins over Start so a new multiplier is never raced by a multiply.
        if (bus.Load_B) begin
          b_d = bus.Din;
          a_d = '0;
          x_d = 1'b0;
        end else if (bus.Start) begin
          // A is not cleared: chained multiplies reuse the previous result halves.
          s_d     = bus.Din;
          mode_d  = SIGNED_EN && bus.Signed_Mode;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        if (b_q[0]) begin
          {x_d, a_d} = as_sum;
        end else begin
          x_d = mode_q ? a_q[WIDTH-1] : 1'b0;
        end
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        // X feeds A's MSB: sign in signed mode, carry in unsigned mode (then cleared).
        a_d = {x_q, a_q[WIDTH-1:1]};
        b_d = {a_q[0], b_q[WIDTH-1:1]};
        x_d = mode_q ? x_q : 1'b0;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ADD;
        end
      end

      ST_DONE: begin
        if (!bus.Start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Status and result outputs straight from the registers.
  always_comb begin
    bus.Busy  = (state_q == ST_ADD) || (state_q == ST_SHIFT);
    bus.Done  = (state_q == ST_DONE);
    bus.A_Out = a_q;
    bus.B_Out = b_q;
    bus.X     = x_q;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=8 and WIDTH=16.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_add_multiplier;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  shift_add_multiplier_if #(.WIDTH(8))  bus8();
  shift_add_multiplier_if #(.WIDTH(16)) bus16();

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus8.slave)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus16.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  localparam logic [15:0] EXP_SMALL   = 16'hFE63;  // 7 * -59 = -413
  localparam logic        EXP_SMALL_X = 1'b1;
`else
  localparam logic [15:0] EXP_SMALL   = 16'h0563;  // 7 * 197 = 1379
  localparam logic        EXP_SMALL_X = 1'b0;
`endif

  task automatic load8(input logic [7:0] v);
    @(negedge Clk);
    bus8.Load_B = 1'b1;
    bus8.Din    = v;
    @(negedge Clk);
    bus8.Load_B = 1'b0;
  endtask

  task automatic load16(input logic [15:0] v);
    @(negedge Clk);
    bus16.Load_B = 1'b1;
    bus16.Din    = v;
    @(negedge Clk);
    bus16.Load_B = 1'b0;
  endtask

  // Raise Start with operand s, count edges after the capture edge until Done; -1 if never.
  // Start stays high so the caller can observe DONE holding.
  task automatic mul8(input logic [7:0] s, input logic sgn, input logic noise, output int lat);
    @(negedge Clk);
    bus8.Start       = 1'b1;
    bus8.Din         = s;
    bus8.Signed_Mode = sgn;
    @(posedge Clk);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk);
      #1;
      if (bus8.Done === 1'b1) begin
        lat = k;
        break;
      end
      if (noise) begin
        bus8.Din         = 8'hA5 ^ 8'(k);
        bus8.Load_B      = k[0];
        bus8.Signed_Mode = ~sgn;
      end
    end
    bus8.Load_B = 1'b0;
    bus8.Din    = '0;
  endtask

  task automatic mul16(input logic [15:0] s, output int lat);
    @(negedge Clk);
    bus16.Start       = 1'b1;
    bus16.Din         = s;
    bus16.Signed_Mode = 1'b0;
    @(posedge Clk);
    lat = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge Clk);
      #1;
      if (bus16.Done === 1'b1) begin
        lat = k;
        break;
      end
    end
    bus16.Din = '0;
  endtask

  task automatic release8;
    @(negedge Clk);
    bus8.Start = 1'b0;
    @(posedge Clk);
    #1;
    checks++;
    if (bus8.Done !== 1'b0) begin
      errors++;
      $display("FAIL release8_idle: Done=%b expected 0", bus8.Done);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    #12;
    checks++;
    if ({bus8.A_Out, bus8.B_Out, bus8.X, bus8.Busy, bus8.Done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_w8: A=%h B=%h X=%b Busy=%b Done=%b expected all 0",
               bus8.A_Out, bus8.B_Out, bus8.X, bus8.Busy, bus8.Done);
    end
    checks++;
    if ({bus16.A_Out, bus16.B_Out, bus16.X, bus16.Busy, bus16.Done} !== 35'd0) begin
      errors++;
      $display("FAIL reset_w16: A=%h B=%h X=%b Busy=%b Done=%b expected all 0",
               bus16.A_Out, bus16.B_Out, bus16.X, bus16.Busy, bus16.Done);
    end
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_signed_small;
    int lat;
    load8(8'h07);
    mul8(8'hC5, 1'b1, 1'b0, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL small_latency: got %0d expected 16", lat);
    end
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== EXP_SMALL) begin
      errors++;
      $display("FAIL small_product: got %h expected %h", {bus8.A_Out, bus8.B_Out}, EXP_SMALL);
    end
    checks++;
    if (bus8.X !== EXP_SMALL_X) begin
      errors++;
      $display("FAIL small_x: got %b expected %b", bus8.X, EXP_SMALL_X);
    end
    // Start still held: must remain in DONE.
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (bus8.Done !== 1'b1 || bus8.Busy !== 1'b0) begin
      errors++;
      $display("FAIL small_hold_done: Done=%b Busy=%b expected 1/0", bus8.Done, bus8.Busy);
    end
    release8();
  endtask

  task automatic test_unsigned_max;
    int lat;
    load8(8'hFF);
    // Din/Load_B/Signed_Mode toggled while busy must be ignored.
    mul8(8'hFF, 1'b0, 1'b1, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL umax_latency: got %0d expected 16", lat);
    end
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== 16'hFE01) begin
      errors++;
      $display("FAIL umax_product: got %h expected fe01", {bus8.A_Out, bus8.B_Out});
    end
    checks++;
    if (bus8.X !== 1'b0) begin
      errors++;
      $display("FAIL umax_x: got %b expected 0", bus8.X);
    end
    release8();
  endtask

  task automatic test_signed_min;
    int lat;
    load8(8'h80);
    mul8(8'h80, 1'b1, 1'b0, lat);
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== 16'h4000 || bus8.X !== 1'b0) begin
      errors++;
      $display("FAIL smin_product: got %h X=%b expected 4000 X=0", {bus8.A_Out, bus8.B_Out}, bus8.X);
    end
    release8();
  endtask

  task automatic test_wide16;
    int lat;
    load16(16'h7FFF);
    mul16(16'h7FFF, lat);
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL w16_latency: got %0d expected 32", lat);
    end
    checks++;
    if ({bus16.A_Out, bus16.B_Out} !== 32'h3FFF0001) begin
      errors++;
      $display("FAIL w16_product: got %h expected 3fff0001", {bus16.A_Out, bus16.B_Out});
    end
    @(negedge Clk);
    bus16.Start = 1'b0;
  endtask

  task automatic test_priority;
    // A holds 0x40 from the previous product; Load_B must clear it and not start.
    @(negedge Clk);
    bus8.Start  = 1'b1;
    bus8.Load_B = 1'b1;
    bus8.Din    = 8'h03;
    @(posedge Clk);
    #1;
    checks++;
    if (bus8.Busy !== 1'b0 || bus8.Done !== 1'b0) begin
      errors++;
      $display("FAIL prio_no_start: Busy=%b Done=%b expected 0/0", bus8.Busy, bus8.Done);
    end
    checks++;
    if (bus8.B_Out !== 8'h03 || bus8.A_Out !== 8'h00 || bus8.X !== 1'b0) begin
      errors++;
      $display("FAIL prio_load: A=%h B=%h X=%b expected 00/03/0", bus8.A_Out, bus8.B_Out, bus8.X);
    end
    @(negedge Clk);
    bus8.Start  = 1'b0;
    bus8.Load_B = 1'b0;
  endtask

  task automatic test_back_to_back;
    int lat;
    mul8(8'h05, 1'b0, 1'b0, lat);   // 3 * 5 = 15
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== 16'h000F) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 000f", {bus8.A_Out, bus8.B_Out});
    end
    release8();
    mul8(8'h02, 1'b0, 1'b0, lat);   // reuses B = 0x0F: 15 * 2 = 30
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== 16'h001E || lat != 16) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected 001e lat 16", {bus8.A_Out, bus8.B_Out}, lat);
    end
    release8();
  endtask

  task automatic test_reset_mid;
    int lat;
    load8(8'h07);
    @(negedge Clk);
    bus8.Start       = 1'b1;
    bus8.Din         = 8'hC5;
    bus8.Signed_Mode = 1'b1;
    @(posedge Clk);
    repeat (5) @(posedge Clk);
    #1;
    checks++;
    if (bus8.Busy !== 1'b1 || bus8.A_Out === 8'h00) begin
      errors++;
      $display("FAIL mid_busy: Busy=%b A=%h expected 1 and nonzero", bus8.Busy, bus8.A_Out);
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus8.A_Out, bus8.B_Out, bus8.X, bus8.Busy, bus8.Done} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset: A=%h B=%h X=%b Busy=%b Done=%b expected all 0",
               bus8.A_Out, bus8.B_Out, bus8.X, bus8.Busy, bus8.Done);
    end
    @(negedge Clk);
    Reset      = 1'b0;
    bus8.Start = 1'b0;
    load8(8'h09);
    mul8(8'h0B, 1'b0, 1'b0, lat);   // 9 * 11 = 99
    checks++;
    if ({bus8.A_Out, bus8.B_Out} !== 16'h0063 || lat != 16) begin
      errors++;
      $display("FAIL mid_after: got %h lat %0d expected 0063 lat 16", {bus8.A_Out, bus8.B_Out}, lat);
    end
    release8();
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    Reset             = 1'b1;
    bus8.Start        = 1'b0;
    bus8.Load_B       = 1'b0;
    bus8.Signed_Mode  = 1'b0;
    bus8.Din          = '0;
    bus16.Start       = 1'b0;
    bus16.Load_B      = 1'b0;
    bus16.Signed_Mode = 1'b0;
    bus16.Din         = '0;

    test_reset();
    test_signed_small();
    test_unsigned_max();
    test_signed_min();
    test_wide16();
    test_priority();
    test_back_to_back();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 Clk  input  1  rising-edge clock; sole clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  level request to multiply; sampled only in IDLE.
REQ-005 Load_B  input  1  loads multiplier B from Din, clears A and X; sampled only in IDLE.
REQ-006 Signed_Mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-007 Din  input  WIDTH  operand bus (multiplier on Load_B, multiplicand on Start).
REQ-008 Busy  output  1  high in ADD and SHIFT states.
REQ-009 Done  output  1  high while in DONE.
REQ-010 A_Out  output  WIDTH  upper product half / accumulator.
REQ-011 B_Out  output  WIDTH  lower product half / multiplier shift register.
REQ-012 X  output  1  extension bit above A.

Function
REQ-013 States SHALL be IDLE, ADD, SHIFT, DONE; iteration counter of $clog2(WIDTH) bits.
REQ-014 IDLE with Load_B=1: B<=Din, A<=0, X<=0; Load_B SHALL win if Start is also high in the same cycle.
REQ-015 IDLE with Start=1, Load_B=0: S<=Din, mode<=Signed_Mode, counter<=0, next state ADD.
REQ-016 ADD: if B[0]=1, {X,A} <= A + S in WIDTH+1 bits (sign-extended when signed, zero-extended when unsigned); if B[0]=0, A unchanged, X <= sign (signed) or 0 (unsigned).
REQ-017 ADD on last iteration (counter=WIDTH-1) in signed mode SHALL subtract S instead of adding.
REQ-018 SHIFT: {X,A,B} SHALL shift right one bit; X retains its value (arithmetic in signed mode; X=carry in unsigned mode).
REQ-019 SHIFT: counter=WIDTH-1 -> DONE, else counter+1 -> ADD.
REQ-020 Latency: Done SHALL assert exactly 2*WIDTH cycles after the edge that captured Start.
REQ-021 DONE: {A_Out,B_Out} holds the 2*WIDTH-bit product; remain in DONE until Start=0, then IDLE.
REQ-022 Start, Load_B, Din changes while Busy SHALL be ignored.
REQ-023 Back-to-back multiply without Load_B SHALL reuse current B (i.e. previous low product half), matching legacy chaining behaviour.

Reset
REQ-024 Reset SHALL asynchronously force IDLE, A=0, B=0, S=0, X=0, counter=0, Busy=0, Done=0, including mid-operation.
REQ-025 First Start after Reset release SHALL be honoured on the first rising edge it is sampled.

Configuration
REQ-026 Macro SHIFT_ADD_MULT_SIGNED_EN defined: signed mode per REQ-016/017 supported.
REQ-027 Macro undefined: Signed_Mode ignored, all operations unsigned, subtract path not synthesised.

Structure
REQ-028 Package mult_pkg SHALL hold the state enum type and a WIDTH-independent localparam for minimum legal WIDTH.
REQ-029 One sub-module addsub_n (parameter WIDTH) SHALL implement the WIDTH+1-bit add/subtract with extension-select input.
REQ-030 Target RTL size 120-400 lines total.

Verification
REQ-031 WIDTH=8 signed: Load_B Din=0x07, Start Din=0xC5 (-59) -> after 16 cycles Done=1, {A,B}=0xFE63 (-413).
REQ-032 WIDTH=8 unsigned: B=0xFF, S=0xFF -> {A,B}=0xFE01, X=0.
REQ-033 WIDTH=8 signed: B=0x80, S=0x80 (-128*-128) -> {A,B}=0x4000.
REQ-034 WIDTH=16 unsigned: B=0x7FFF, S=0x7FFF -> {A,B}=0x3FFF0001, Done at cycle 32.
REQ-035 Reset asserted at cycle 5 of a WIDTH=8 multiply -> all outputs 0 immediately, IDLE; Start afterwards completes correctly.
REQ-036 Start and Load_B both high in IDLE -> B loaded, no multiply started; Start held in DONE -> stays DONE until Start=0.
